// File: rtl/rv32i_pkg.sv
// Shared rv32i core definitions: reset PC, canonical NOP, fetch state encoding.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // A fetch target must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// Single-entry IF/ID output register with valid/ready handshake and flush.
module fetch_slot
  import rv32i_pkg::*;
#(
  parameter int unsigned AW = XLEN,
  parameter int unsigned DW = XLEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          flush,
  input  logic          ready,
  input  logic [DW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  output logic          valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic          free_c
);

  assign free_c = !valid || ready;

  // Flush wins over load; a consumed entry with nothing behind it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= DW'(INSTR_NOP);
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, feeds the IF/ID slot and halts on misaligned redirects.
module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter int unsigned   AW       = XLEN,
  parameter int unsigned   DW       = XLEN,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [DW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  output logic          fetch_fault,
  output logic [AW-1:0] fault_pc,
  output logic [31:0]   fetch_count
);

  localparam int unsigned CW = 32;

  fetch_state_e  state, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          fault_q, fault_d;
  logic [AW-1:0] fault_pc_q, fault_pc_d;
  logic [CW-1:0] count_q;
  logic          slot_load_c;
  logic          slot_flush_c;
  logic          slot_free_c;
  logic          fire_c;

  fetch_slot #(
    .AW (AW),
    .DW (DW)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (slot_load_c),
    .flush    (slot_flush_c),
    .ready    (id_ready),
    .in_instr (imem_data),
    .in_pc    (pc_q),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc),
    .free_c   (slot_free_c)
  );

  assign fire_c = id_valid && id_ready;

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state      <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Next-state: redirect beats both stall and fill; FAULT is terminal until reset.
  always_comb begin
    state_d      = state;
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_pc_d   = fault_pc_q;
    slot_load_c  = 1'b0;
    slot_flush_c = 1'b0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          slot_flush_c = 1'b1;
          if (is_misaligned(redirect_pc[1:0])) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (slot_free_c) begin
          slot_load_c = 1'b1;
          pc_d        = pc_q + AW'(INSTR_BYTES);
        end
      end
      FAULT: begin
        slot_flush_c = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Handshake counter; a flushed-but-consumed slot still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (fire_c) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the rv32i single-cycle-derived core: owns the program counter, drives the byte address into the combinational instruction memory and registers the returned 32-bit word into an IF/ID output slot. The slot has a valid/ready handshake toward decode. It also accepts branch/jump redirects from execute and traps misaligned redirect targets. Sits directly upstream of `instruction_memory` (address producer) and between it and decode (data consumer).

## Interface
- `AW`, 32, address width; PC and memory address width.
- `DW`, 32, instruction width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_addr`  out  AW  byte address to instruction memory; equals PC.
- `imem_data`  in  DW  instruction word returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  execute requests PC change this cycle.
- `redirect_pc`  in  AW  redirect target byte address.
- `id_valid`  out  1  output slot holds a valid instruction.
- `id_ready`  in  1  decode accepts the slot this cycle.
- `id_instr`  out  DW  fetched instruction.
- `id_pc`  out  AW  address of `id_instr`.
- `fetch_fault`  out  1  sticky; misaligned redirect seen, fetch halted.
- `fault_pc`  out  AW  offending redirect target.
- `fetch_count`  out  32  number of completed id handshakes, wraps.

## Operation
- States: RUN, FAULT. Reset enters RUN.
- Slot "free" = `!id_valid || id_ready`.
- RUN, no redirect, slot free: slot <= {1, `imem_data`, PC}; PC <= PC + 4 (mod 2^AW, wraps silently).
- RUN, no redirect, slot not free: PC, slot, all outputs held stable (stall).
- RUN, redirect with `redirect_pc[1:0]==0`: `id_valid` <= 0 (flush), PC <= `redirect_pc`; redirect has priority over stall and over fill.
- RUN, redirect with `redirect_pc[1:0]!=0`: state <= FAULT, `fetch_fault` <= 1, `fault_pc` <= `redirect_pc`, `id_valid` <= 0, PC unchanged.
- FAULT: no fetch, `id_valid` stays 0, redirects ignored; exit only by `rst`.
- `fetch_count` increments on every cycle with `id_valid && id_ready`, including the cycle a redirect flushes the slot (that instruction is consumed).
- Outputs do not depend combinationally on `id_ready` or `redirect_*`; `imem_addr` is a register output.

## Timing
- Reset values: PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_instr`=32'h0000_0013 (NOP), `id_pc`=0, `fetch_fault`=0, `fault_pc`=0, `fetch_count`=0.
- Reset assertion mid-operation clears all state immediately (asynchronous); first fill occurs on first rising edge with `rst` low.
- Latency PC->`id_valid`: 1 cycle. Steady throughput 1 instruction/cycle with `id_ready` high.
- Redirect at edge N: edge N+1 `id_valid`=0, `imem_addr`=target; edge N+2 `id_valid`=1 with `id_pc`=target. Exactly one bubble.
- While `id_valid && !id_ready`, `id_instr`/`id_pc` must not change.

## Structure
- Shared package `rv32i_pkg`: `RESET_PC` default, `INSTR_NOP` = 32'h0000_0013, state encoding (RUN, FAULT), XLEN=32.
- One sub-module, `fetch_slot`: the single-entry valid/ready output register with flush input; the PC/FSM/counter logic lives in `instruction_fetch`.

## Test plan
- Reset, hold `id_ready`=1, memory holds words W0..W3 at 0x0..0xC -> `id_pc` 0,4,8,C on consecutive cycles, `fetch_count`=4 after 4th handshake.
- `id_ready`=0 for 3 cycles while `id_pc`=4 -> `id_instr`/`id_pc`/`imem_addr` stable, count unchanged; release -> `id_pc`=8 next cycle.
- Redirect to 0x100 while `id_valid`=1, `id_ready`=0 -> next cycle `id_valid`=0, following cycle `id_pc`=0x100; count unchanged.
- Redirect to 0x102 -> `fetch_fault`=1, `fault_pc`=0x102, `id_valid` stays 0 through later redirect to 0x200; `rst` clears fault and PC=`RESET_PC`.
- PC at 0xFFFF_FFFC, `id_ready`=1 -> next `id_pc`=0xFFFF_FFFC then 0x0000_0000 (wrap).
- Assert `rst` between edges mid-stream -> outputs reach reset values before the next edge.
